// File: rtl/uart_pkg.sv
// Shared UART definitions: data width and feeder FSM state codes.
// Used by the transmit feeder and the UART core.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARM  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

endpackage

// File: rtl/uart_sync_fifo.sv
// Register-array synchronous FIFO with push/pop/flush,
// level-derived full/empty and a sticky overflow flag.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int DATA_W = UART_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level,
  output logic              overflow
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   cnt;
  logic              do_push;
  logic              do_pop;

  assign full  = (cnt == (ADDR_W+1)'(DEPTH));
  assign empty = (cnt == '0);
  assign level = cnt;

  assign rd_data = mem[rd_ptr];

  // A pop frees a slot in the same edge, so a full FIFO may still accept.
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      unique case (1'b1)
        do_push && !do_pop: cnt <= cnt + 1'b1;
        !do_push && do_pop: cnt <= cnt - 1'b1;
        default:            cnt <= cnt;
      endcase
      if (push && !do_push)
        overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Transmit buffer feeding the UART core one byte per frame,
// paced by tx_busy, with back-to-back frames from a FIFO.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [UART_DATA_W-1:0] wr_data,
  input  logic                   wr_en,
  input  logic                   flush,
  output logic                   full,
  output logic                   empty,
  output logic [ADDR_W:0]        level,
  output logic                   overflow,
  output logic [UART_DATA_W-1:0] tx_data,
  output logic                   tx_start,
  input  logic                   tx_busy
);

  logic [1:0]             state;
  logic [1:0]             state_nxt;
  logic                   pop;
  logic [UART_DATA_W-1:0] head;

  uart_sync_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (UART_DATA_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .push     (wr_en),
    .pop      (pop),
    .wr_data  (wr_data),
    .rd_data  (head),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .overflow (overflow)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (pop) state_nxt = S_ARM;
      S_ARM:  if (tx_busy) state_nxt = S_WAIT;
      S_WAIT: if (!tx_busy) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // A flushed FIFO must not launch its stale head.
  always_comb begin
    pop = (state == S_IDLE) && !empty && !tx_busy && !flush;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_start <= 1'b0;
      tx_data  <= '0;
    end else begin
      tx_start <= pop;
      if (pop)
        tx_data <= head;
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Randomized bench for uart_tx_feeder against a queue-based
// reference model, with a simple transmitter busy model.
module tb_uart_tx_feeder;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        wr_data;
  logic              wr_en;
  logic              flush;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   level;
  logic              overflow;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic              tx_busy;

  always #5 clk = ~clk;

  uart_tx_feeder #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .flush    (flush),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .overflow (overflow),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_busy  (tx_busy)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // transmitter: busy from the edge after tx_start for busy_len cycles
  int   busy_cnt;
  int   busy_len = 20;
  bit   busy_rand = 0;
  logic hold_busy = 1'b0;

  assign tx_busy = hold_busy || (busy_cnt != 0);

  always @(posedge clk or posedge rst) begin
    if (rst)
      busy_cnt <= 0;
    else if (tx_start)
      busy_cnt <= busy_rand ? int'($urandom_range(1, 20)) : busy_len;
    else if (busy_cnt != 0)
      busy_cnt <= busy_cnt - 1;
  end

  // reference model: byte queue plus a "frame in progress" notion
  logic [7:0] q[$];
  bit         m_ovf;
  bit         m_frame;
  bit         m_seen;
  bit         m_start;
  logic [7:0] m_data;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_ovf   = 0;
      m_frame = 0;
      m_seen  = 0;
      m_start = 0;
      m_data  = 8'h00;
    end else begin
      bit send;
      send = !m_frame && (q.size() > 0) && !tx_busy && !flush;
      if (m_frame) begin
        if (!m_seen) begin
          if (tx_busy) m_seen = 1;
        end else if (!tx_busy) begin
          m_frame = 0;
        end
      end
      m_start = send;
      if (send) begin
        m_data  = q.pop_front();
        m_frame = 1;
        m_seen  = 0;
      end
      if (flush) begin
        q.delete();
        m_ovf = 0;
      end else if (wr_en) begin
        if (q.size() < DEPTH) q.push_back(wr_data);
        else m_ovf = 1;
      end
    end
  end

  bit         mon_en = 0;
  int         n_starts = 0;
  logic [7:0] seen_q[$];

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      chk("level", level, q.size());
      chk("full", full, q.size() == DEPTH);
      chk("empty", empty, q.size() == 0);
      chk("overflow", overflow, m_ovf);
      chk("tx_start", tx_start, m_start);
      chk("tx_data", tx_data, m_data);
      chk("start_busy", tx_start & tx_busy, 0);
      if (tx_start) begin
        n_starts++;
        seen_q.push_back(tx_data);
      end
    end
  end

  task automatic step(input logic we, input logic [7:0] d, input logic fl);
    @(negedge clk);
    #1;
    wr_en   = we;
    wr_data = d;
    flush   = fl;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  task automatic wait_drain(input int limit);
    bit done;
    done = 0;
    for (int i = 0; i < limit && !done; i++) begin
      step(1'b0, 8'h00, 1'b0);
      if (q.size() == 0 && !m_frame && !tx_busy) done = 1;
    end
    if (!done) chk("drain_timeout", 1, 0);
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, "_full"}, full, 0);
    chk({tag, "_empty"}, empty, 1);
    chk({tag, "_level"}, level, 0);
    chk({tag, "_ovf"}, overflow, 0);
    chk({tag, "_data"}, tx_data, 8'h00);
    chk({tag, "_start"}, tx_start, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int snap;
    logic [7:0] exp_bytes[$];
    rst = 1'b1;
    wr_en = 1'b0;
    wr_data = 8'h00;
    flush = 1'b0;
    #1;
    chk_reset_vals("por");
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    mon_en = 1;

    // 1: single byte, start two cycles after the write
    step(1'b1, 8'hA5, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("t1_nostart", tx_start, 0);
    step(1'b0, 8'h00, 1'b0);
    chk("t1_start", tx_start, 1);
    chk("t1_data", tx_data, 8'hA5);
    chk("t1_empty", empty, 1);
    wait_drain(100);

    // 2: burst of three with long frames
    seen_q.delete();
    snap = n_starts;
    step(1'b1, 8'h11, 1'b0);
    step(1'b1, 8'h22, 1'b0);
    step(1'b1, 8'h33, 1'b0);
    wait_drain(200);
    chk("t2_count", n_starts - snap, 3);
    chk("t2_b0", seen_q.size() > 0 ? seen_q[0] : 8'hxx, 8'h11);
    chk("t2_b1", seen_q.size() > 1 ? seen_q[1] : 8'hxx, 8'h22);
    chk("t2_b2", seen_q.size() > 2 ? seen_q[2] : 8'hxx, 8'h33);

    // 3: overfill while busy, then drain the first DEPTH bytes
    seen_q.delete();
    exp_bytes.delete();
    hold_busy = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      if (i < DEPTH) exp_bytes.push_back(b);
      step(1'b1, b, 1'b0);
    end
    step(1'b0, 8'h00, 1'b0);
    chk("t3_full", full, 1);
    chk("t3_level", level, DEPTH);
    chk("t3_ovf", overflow, 1);
    hold_busy = 1'b0;
    busy_len = 3;
    wait_drain(600);
    chk("t3_count", seen_q.size(), DEPTH);
    for (int i = 0; i < DEPTH && i < seen_q.size(); i++)
      chk("t3_order", seen_q[i], exp_bytes[i]);

    // 4: write on the pop cycle while full
    step(1'b0, 8'h00, 1'b1);
    hold_busy = 1'b1;
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'($urandom), 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("t4_full", full, 1);
    @(negedge clk);
    #1;
    hold_busy = 1'b0;
    wr_en = 1'b1;
    wr_data = 8'h5C;
    flush = 1'b0;
    step(1'b0, 8'h00, 1'b0);
    chk("t4_level", level, DEPTH);
    chk("t4_ovf", overflow, 0);
    wait_drain(600);

    // 5: flush during a frame; the frame completes, nothing follows
    busy_len = 20;
    step(1'b1, 8'h77, 1'b0);
    idle(4);
    for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), 1'b0);
    snap = n_starts;
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    chk("t5_level", level, 0);
    chk("t5_ovf", overflow, 0);
    wait_drain(100);
    idle(5);
    chk("t5_nostart", n_starts - snap, 0);

    // 6: asynchronous reset while armed with four bytes queued
    hold_busy = 1'b1;
    for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), 1'b0);
    @(negedge clk);
    #1;
    hold_busy = 1'b0;
    wr_en = 1'b0;
    @(negedge clk);
    chk("t6_armed", tx_start, 1);
    chk("t6_queued", level, 4);
    #2 rst = 1'b1;
    #1;
    chk_reset_vals("t6");
    @(negedge clk);
    #1 rst = 1'b0;
    snap = n_starts;
    idle(30);
    chk("t6_nostart", n_starts - snap, 0);

    // random traffic with random frame lengths and rare flushes
    busy_rand = 1;
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 2) == 0, 8'($urandom),
           $urandom_range(0, 59) == 0);
    wait_drain(800);

    mon_en = 0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
